// File: rtl/result_arb_pkg.sv
// Shared types, sizes and the round-robin search used by the result-bus arbiter
// and by any other arbiter that needs the same rotating-priority scan.
package result_arb_pkg;

    localparam int unsigned ARB_NUM_REQ = 9;
    localparam int unsigned ARB_DATA_W  = 32;
    localparam int unsigned ARB_SEL_W   = 4;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } arb_state_e;

    typedef struct packed {
        logic [ARB_SEL_W-1:0] idx;
        logic                 found;
    } rr_result_t;

    // First set bit of valid, starting just after last and wrapping at ARB_NUM_REQ-1.
    function automatic rr_result_t rr_next(input logic [ARB_NUM_REQ-1:0] valid,
                                           input logic [ARB_SEL_W-1:0]   last);
        rr_result_t  r;
        int unsigned k;
        r.idx   = '0;
        r.found = 1'b0;
        for (int unsigned off = 1; off <= ARB_NUM_REQ; off++) begin
            k = (32'(last) + off) % ARB_NUM_REQ;
            if (!r.found && valid[k]) begin
                r.idx   = ARB_SEL_W'(k);
                r.found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/result_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin index picker over up to ARB_NUM_REQ requesters.
module rr_pick
    import result_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = ARB_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]   valid,
    input  logic [ARB_SEL_W-1:0] last,
    output logic [ARB_SEL_W-1:0] idx,
    output logic                 found
);

    logic [ARB_NUM_REQ-1:0] valid_ext;
    rr_result_t             res;

    // Unused upper slots stay zero, so scanning the full width wraps exactly at NUM_REQ-1.
    always_comb begin
        valid_ext              = '0;
        valid_ext[NUM_REQ-1:0] = valid;
        res                    = rr_next(valid_ext, last);
        idx                    = res.idx;
        found                  = res.found;
    end

endmodule

// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter for the shared result mux with a one-entry output register.
// Define RESULT_ARB_PRIO0_EN to give requester 0 fixed priority over the round-robin group.
module result_bus_arbiter
    import result_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = ARB_NUM_REQ,
    parameter int unsigned DATA_W  = ARB_DATA_W,
    parameter int unsigned SEL_W   = ARB_SEL_W
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [SEL_W-1:0]          mux_sel,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SEL_W-1:0]          out_src,
    input  logic                      out_ready
);

    arb_state_e           state_q, state_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]     out_src_q, out_src_d;
    logic [SEL_W-1:0]     last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0]   rr_valid;
    logic [ARB_SEL_W-1:0] rr_idx;
    logic                 rr_found;
    logic [SEL_W-1:0]     pick_idx;
    logic                 pick_found;
    logic                 move_ptr;
    logic                 can_load;
    logic                 grant;

    always_comb begin
        rr_valid = req_valid;
`ifdef RESULT_ARB_PRIO0_EN
        rr_valid[0] = 1'b0;
`endif
    end

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .valid (rr_valid),
        .last  (ARB_SEL_W'(last_grant_q)),
        .idx   (rr_idx),
        .found (rr_found)
    );

    always_comb begin
        pick_idx   = SEL_W'(rr_idx);
        pick_found = rr_found;
        move_ptr   = 1'b1;
`ifdef RESULT_ARB_PRIO0_EN
        if (req_valid[0]) begin
            pick_idx   = '0;
            pick_found = 1'b1;
            move_ptr   = 1'b0;
        end
`endif
    end

    // Idle select shows the last loaded source; out_src_q tracks last_grant after any
    // round-robin grant and is still zero straight out of reset.
    always_comb begin
        can_load     = (state_q == ST_EMPTY) || out_ready;
        grant        = can_load && pick_found;
        req_ready    = '0;
        mux_sel      = out_src_q;
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        if (grant) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (pick_idx == SEL_W'(i)) begin
                    req_ready[i] = 1'b1;
                    out_data_d   = req_data[i*DATA_W +: DATA_W];
                end
            end
            mux_sel   = pick_idx;
            out_src_d = pick_idx;
            state_d   = ST_FULL;
            if (move_ptr) begin
                last_grant_d = pick_idx;
            end
        end else if (can_load) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_EMPTY;
            out_data_q   <= '0;
            out_src_q    <= '0;
            last_grant_q <= SEL_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

    a_grant_onehot: assert property (@(posedge CLK) disable iff (!RESET) $onehot0(req_ready));

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed bench for result_bus_arbiter; the RESULT_ARB_PRIO0_EN build runs the fixed-priority vectors.
module tb_result_bus_arbiter;

    localparam int unsigned N  = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    logic            CLK;
    logic            RESET;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [SW-1:0]   mux_sel;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
    logic            out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    result_bus_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SEL_W(SW)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .mux_sel   (mux_sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        #1;
    endtask

    logic [N-1:0] exp_rdy;
    int           src;

    initial begin
        RESET     = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        #2;
        RESET = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data,        32'd0);
        check("rst_out_src",   32'(out_src),   32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_mux_sel",   32'(mux_sel),   32'd0);
        tick();
        RESET = 1'b1;
        tick();
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_req_ready", 32'(req_ready), 32'd0);

`ifndef RESULT_ARB_PRIO0_EN
        // full round robin, ten back-to-back results: 0..8 then 0
        req_valid = 9'h1FF;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            src     = k % 9;
            exp_rdy = 9'b1 << src;
            #1;
            check("rr_req_ready", 32'(req_ready), 32'(exp_rdy));
            check("rr_mux_sel",   32'(mux_sel),   32'(src));
            tick();
            check("rr_out_valid", 32'(out_valid), 32'd1);
            check("rr_out_src",   32'(out_src),   32'(src));
            check("rr_out_data",  out_data,        32'hA000_0000 + 32'(src));
        end

        // advance to out_src=3, then backpressure
        tick(); tick(); tick();
        check("bp_setup_src", 32'(out_src), 32'd3);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_mux_sel",   32'(mux_sel),   32'd3);
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data",  out_data,        32'hA000_0003);
            check("bp_out_src",   32'(out_src),   32'd3);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'h010);
        check("bp_release_sel",   32'(mux_sel),   32'd4);
        tick();
        check("bp_release_src",   32'(out_src),   32'd4);

        // grants 5,6,7 then sparse request set wraps to 0 then 1
        tick(); tick(); tick();
        check("wrap_setup_src", 32'(out_src), 32'd7);
        req_valid = 9'h003;
        #1;
        check("wrap_ready0", 32'(req_ready), 32'h001);
        tick();
        check("wrap_src0",   32'(out_src),   32'd0);
        check("wrap_ready1", 32'(req_ready), 32'h002);
        tick();
        check("wrap_src1",   32'(out_src),   32'd1);
        check("wrap_data1",  out_data,        32'hA000_0001);
        req_valid = '0;
        #1;
        check("idle_ready",   32'(req_ready), 32'd0);
        check("idle_mux_sel", 32'(mux_sel),   32'd1);
        tick();
        check("drain_valid",  32'(out_valid), 32'd0);
        tick();
        check("empty_hold",   32'(out_valid), 32'd0);

        // reset while holding a result
        req_data[2*DW +: DW] = 32'hDEAD_BEEF;
        req_valid = 9'h004;
        tick();
        check("mid_full_data", out_data,        32'hDEAD_BEEF);
        check("mid_full_src",  32'(out_src),   32'd2);
        req_valid = '0;
        out_ready = 1'b0;
        #2;
        RESET = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  out_data,        32'd0);
        tick();
        RESET = 1'b1;
        req_valid = 9'h1FF;
        out_ready = 1'b1;
        #1;
        check("mid_rst_regrant", 32'(req_ready), 32'h001);
        tick();
        check("mid_rst_src",     32'(out_src),   32'd0);
        check("mid_rst_newdata", out_data,        32'hA000_0000);
`else
        // requester 0 dominates, the rest rotate among themselves
        req_valid = 9'h111;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("p0_ready", 32'(req_ready), 32'h001);
            tick();
            check("p0_src",   32'(out_src),   32'd0);
        end
        req_valid = 9'h110;
        for (int k = 0; k < 3; k++) begin
            src = (k == 1) ? 8 : 4;
            exp_rdy = 9'b1 << src;
            #1;
            check("p0_rr_ready", 32'(req_ready), 32'(exp_rdy));
            tick();
            check("p0_rr_src",   32'(out_src),   32'(src));
        end
        do_reset();
        req_valid = 9'h001;
        #1;
        check("p0_after_rst", 32'(req_ready), 32'h001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
